ahb_addr_decoder: RTL and testbench

Parametrised AHB address decoder and response multiplexer for the multi-master interconnect, sitting between the arbiter and the slave array. It selects the granted master's address-phase signals and decodes them against per-slave base/mask regions to drive one-hot `hsel`. It registers the data-phase owner to steer the response and read-data muxes. An internal default slave returns a two-cycle ERROR to active transfers that hit no region.

---
 rtl/ahb_addr_decoder.sv | 161 ++++++++++++++++
 tb/tb_ahb_addr_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_addr_decoder.sv
// AHB address decoder and response multiplexer: decodes the granted master's
// address into a one-hot slave select and steers the data-phase response.
module ahb_addr_decoder #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [MW-1:0]                 hmaster,
    input  logic [NUM_MASTERS*ADDR_W-1:0] haddr_m,
    input  logic [NUM_MASTERS*2-1:0]      htrans_m,
    input  logic [NUM_SLAVES-1:0]         hreadyout_s,
    input  logic [NUM_SLAVES-1:0]         hresp_s,
    output logic [NUM_SLAVES-1:0]         hsel,
    output logic [SW-1:0]                 mux_sel_slave,
    output logic                          dp_default,
    output logic                          hready,
    output logic                          hresp
);

    localparam logic [MW:0] NM = NUM_MASTERS[MW:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    logic [MW-1:0]         w_cur_idx;
    logic [ADDR_W-1:0]     w_cur_addr;
    logic [1:0]            w_cur_trans;
    logic [NUM_SLAVES-1:0] w_match;
    logic                  w_hit;
    logic [SW-1:0]         w_hit_idx;
    logic                  w_unmapped_active;
    logic                  w_fsm_hready;
    logic                  w_fsm_hresp;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_mux_sel_slave;
    logic                  r_dp_default;

    // Out-of-range grants fall back to master 0.
    assign w_cur_idx   = ({1'b0, hmaster} < NM) ? hmaster : {MW{1'b0}};
    assign w_cur_addr  = haddr_m[w_cur_idx*ADDR_W +: ADDR_W];
    assign w_cur_trans = htrans_m[w_cur_idx*2 +: 2];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
        assign w_match[g] = ((w_cur_addr & SLV_MASK[g*ADDR_W +: ADDR_W])
                             == SLV_BASE[g*ADDR_W +: ADDR_W]);
    end

    // Priority select of the matching region; scanning downwards lets the lowest index win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = {SW{1'b0}};
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = i[SW-1:0];
            end else begin
                w_hit     = w_hit;
                w_hit_idx = w_hit_idx;
            end
        end
    end

    // One-hot address-phase select, independent of HTRANS and hready.
    always_comb begin
        hsel = {NUM_SLAVES{1'b0}};
        if (w_hit) begin
            hsel[w_hit_idx] = 1'b1;
        end else begin
            hsel = {NUM_SLAVES{1'b0}};
        end
    end

    assign w_unmapped_active = ~w_hit & w_cur_trans[1];

    // Data-phase owner register, advanced only when the bus is ready.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_mux_sel_slave <= {SW{1'b0}};
            r_dp_default    <= 1'b0;
        end else if (hready) begin
            r_mux_sel_slave <= w_hit ? w_hit_idx : r_mux_sel_slave;
            r_dp_default    <= w_unmapped_active;
        end else begin
            r_mux_sel_slave <= r_mux_sel_slave;
            r_dp_default    <= r_dp_default;
        end
    end

    // Default-slave state register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Default-slave next state; ERR2 always has hready high so it may chain into ERR1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = (hready && w_unmapped_active) ? ST_ERR1 : ST_IDLE;
            ST_ERR1: w_state_nxt = ST_ERR2;
            ST_ERR2: w_state_nxt = w_unmapped_active ? ST_ERR1 : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Default-slave response outputs: two-cycle ERROR.
    always_comb begin
        w_fsm_hready = 1'b1;
        w_fsm_hresp  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_fsm_hready = 1'b1;
                w_fsm_hresp  = 1'b0;
            end
            ST_ERR1: begin
                w_fsm_hready = 1'b0;
                w_fsm_hresp  = 1'b1;
            end
            ST_ERR2: begin
                w_fsm_hready = 1'b1;
                w_fsm_hresp  = 1'b1;
            end
            default: begin
                w_fsm_hready = 1'b1;
                w_fsm_hresp  = 1'b0;
            end
        endcase
    end

    // Response mux steered by the registered data-phase owner.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        if (r_dp_default) begin
            hready = w_fsm_hready;
            hresp  = w_fsm_hresp;
        end else begin
            hready = hreadyout_s[r_mux_sel_slave];
            hresp  = hresp_s[r_mux_sel_slave];
        end
    end

    assign mux_sel_slave = r_mux_sel_slave;
    assign dp_default    = r_dp_default;

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Self-checking bench for ahb_addr_decoder: directed vectors, a per-cycle
// reference model and literal spot checks.
module tb_ahb_addr_decoder;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [1:0]  hmaster = 2'd0;
    logic [95:0] haddr_m = 96'd0;
    logic [5:0]  htrans_m = 6'd0;
    logic [3:0]  hreadyout_s = 4'hF;
    logic [3:0]  hresp_s = 4'h0;
    logic [3:0]  hsel;
    logic [1:0]  mux_sel_slave;
    logic        dp_default;
    logic        hready;
    logic        hresp;

    int total = 0;
    int bad = 0;

    logic [31:0] base_a [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    localparam logic [31:0] REGION_MASK = 32'hF000_0000;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

    // Model state: data-phase slave, default-slave ownership, error phase (1 = stall, 2 = complete)
    logic [1:0] m_sel = 2'd0;
    logic       m_dp = 1'b0;
    logic [1:0] m_phase = 2'd0;

    ahb_addr_decoder dut (
        .hclk(hclk), .hreset(hreset), .hmaster(hmaster), .haddr_m(haddr_m),
        .htrans_m(htrans_m), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
        .hsel(hsel), .mux_sel_slave(mux_sel_slave), .dp_default(dp_default),
        .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    function automatic int mdl_master();
        return (hmaster < 2'd3) ? int'(hmaster) : 0;
    endfunction

    function automatic int mdl_region();
        logic [31:0] a;
        a = haddr_m[mdl_master()*32 +: 32];
        for (int i = 0; i < 4; i++) begin
            if ((a & REGION_MASK) == base_a[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic mdl_active();
        logic [1:0] t;
        t = htrans_m[mdl_master()*2 +: 2];
        return (t == T_NSEQ) || (t == 2'b11);
    endfunction

    function automatic logic [3:0] mdl_hsel();
        int r;
        r = mdl_region();
        return (r < 0) ? 4'b0000 : (4'b0001 << r);
    endfunction

    function automatic logic mdl_hready();
        return m_dp ? (m_phase != 2'd1) : hreadyout_s[m_sel];
    endfunction

    function automatic logic mdl_hresp();
        return m_dp ? 1'b1 : hresp_s[m_sel];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model update.
    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            m_sel   <= 2'd0;
            m_dp    <= 1'b0;
            m_phase <= 2'd0;
        end else if (mdl_hready()) begin
            if (mdl_region() >= 0) m_sel <= 2'(mdl_region());
            m_dp    <= (mdl_region() < 0) && mdl_active();
            m_phase <= ((mdl_region() < 0) && mdl_active()) ? 2'd1 : 2'd0;
        end else if (m_phase == 2'd1) begin
            m_phase <= 2'd2;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge hclk) begin
        chk("cyc_hsel", 32'(hsel), 32'(mdl_hsel()));
        chk("cyc_mux_sel", 32'(mux_sel_slave), 32'(m_sel));
        chk("cyc_dp_default", 32'(dp_default), 32'(m_dp));
        chk("cyc_hready", 32'(hready), 32'(mdl_hready()));
        chk("cyc_hresp", 32'(hresp), 32'(mdl_hresp()));
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic [1:0] t);
        haddr_m[m*32 +: 32] = a;
        htrans_m[m*2 +: 2]  = t;
    endtask

    initial begin
        tick();
        tick();
        hreset = 1'b0;
        #1;
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_mux_sel", 32'(mux_sel_slave), 32'd0);
        chk("rst_dp_default", 32'(dp_default), 32'd0);

        // Basic decode of slave 1 and data-phase steering
        hmaster = 2'd0;
        set_m(0, 32'h1000_0040, T_NSEQ);
        #1 chk("dec_s1_hsel", 32'(hsel), 32'h2);
        tick();
        set_m(0, 32'h1000_0040, T_IDLE);
        #1 chk("dp_s1_mux_sel", 32'(mux_sel_slave), 32'd1);
        chk("dp_s1_hready", 32'(hready), 32'd1);
        hreadyout_s = 4'b1101;
        hresp_s     = 4'b0010;
        #1 chk("dp_s1_hready_low", 32'(hready), 32'd0);
        chk("dp_s1_hresp", 32'(hresp), 32'd1);
        tick();
        hreadyout_s = 4'hF;
        hresp_s     = 4'h0;
        tick();

        // Master selection, including an out-of-range grant
        set_m(0, 32'h0000_0000, T_IDLE);
        set_m(2, 32'h3000_0000, T_IDLE);
        hmaster = 2'd2;
        #1 chk("m2_hsel", 32'(hsel), 32'h8);
        hmaster = 2'd3;
        #1 chk("m3_oor_hsel", 32'(hsel), 32'h1);
        tick();

        // Unmapped NONSEQ: two-cycle ERROR then IDLE
        hmaster = 2'd0;
        set_m(0, 32'h5000_0000, T_NSEQ);
        #1 chk("unmapped_hsel", 32'(hsel), 32'h0);
        tick();
        set_m(0, 32'h5000_0000, T_IDLE);
        #1 chk("err1_hready", 32'(hready), 32'd0);
        chk("err1_hresp", 32'(hresp), 32'd1);
        chk("err1_dp_default", 32'(dp_default), 32'd1);
        tick();
        chk("err2_hready", 32'(hready), 32'd1);
        chk("err2_hresp", 32'(hresp), 32'd1);
        tick();
        chk("post_err_hready", 32'(hready), 32'd1);
        chk("post_err_hresp", 32'(hresp), 32'd0);
        chk("post_err_dp", 32'(dp_default), 32'd0);

        // Back-to-back unmapped transfers chain without an IDLE gap
        set_m(0, 32'h5000_0000, T_NSEQ);
        tick();
        tick();
        chk("b2b_err2_hready", 32'(hready), 32'd1);
        tick();
        chk("b2b_err1_hready", 32'(hready), 32'd0);
        chk("b2b_err1_hresp", 32'(hresp), 32'd1);
        set_m(0, 32'h5000_0000, T_IDLE);
        tick();
        tick();
        chk("b2b_done_hresp", 32'(hresp), 32'd0);

        // IDLE and BUSY to unmapped space complete with OKAY
        set_m(0, 32'h5000_0000, T_IDLE);
        tick();
        chk("idle_unmapped_dp", 32'(dp_default), 32'd0);
        chk("idle_unmapped_hready", 32'(hready), 32'd1);
        set_m(0, 32'h6000_0000, T_BUSY);
        tick();
        chk("busy_unmapped_hready", 32'(hready), 32'd1);

        // Slave 2 stalls while the grant and address move
        set_m(0, 32'h2000_0000, T_NSEQ);
        tick();
        hreadyout_s = 4'b1011;
        hmaster = 2'd1;
        set_m(1, 32'h1000_0000, T_NSEQ);
        #1 chk("stall0_mux_sel", 32'(mux_sel_slave), 32'd2);
        chk("stall0_hready", 32'(hready), 32'd0);
        tick();
        chk("stall1_mux_sel", 32'(mux_sel_slave), 32'd2);
        tick();
        chk("stall2_mux_sel", 32'(mux_sel_slave), 32'd2);
        hreadyout_s = 4'hF;
        #1 chk("stall_end_mux_sel", 32'(mux_sel_slave), 32'd2);
        chk("stall_end_hready", 32'(hready), 32'd1);
        tick();
        chk("stall_after_mux_sel", 32'(mux_sel_slave), 32'd1);
        set_m(1, 32'h1000_0000, T_IDLE);
        tick();

        // Reset during ERR1 clears the response asynchronously
        hmaster = 2'd0;
        set_m(0, 32'h7000_0000, T_NSEQ);
        tick();
        chk("rst_err1_hready_pre", 32'(hready), 32'd0);
        hreset = 1'b1;
        #1 chk("rst_err1_hready", 32'(hready), 32'd1);
        chk("rst_err1_hresp", 32'(hresp), 32'd0);
        chk("rst_err1_dp", 32'(dp_default), 32'd0);
        tick();
        hreset = 1'b0;
        set_m(0, 32'h2000_0000, T_NSEQ);
        #1 chk("post_rst_hsel", 32'(hsel), 32'h4);
        tick();
        set_m(0, 32'h2000_0000, T_IDLE);
        #1 chk("post_rst_mux_sel", 32'(mux_sel_slave), 32'd2);
        chk("post_rst_hready", 32'(hready), 32'd1);
        chk("post_rst_hresp", 32'(hresp), 32'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
